// File: rtl/mash_pkg.sv
// -----------------------------------------------------------------------------
// mash_pkg
// Shared defaults for the MASH serial link: frame width, EFM1 accumulator
// width and link-stall timeout. The truncator stage upstream uses the same
// values, so changing them here keeps both ends of the link in agreement.
// Also provides a small width helper for counters.
// -----------------------------------------------------------------------------
package mash_pkg;

    // Minimum counter width able to hold values 0..n-1, never narrower than 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int FRAME_BITS = 3;     // bits per serial frame, LSB first
    localparam int ACC_W      = 4;     // EFM1 accumulator width
    localparam int TIMEOUT    = 1024;  // idle clck cycles before a partial frame is dropped

    // Width of the in-frame bit counter (counts 0..FRAME_BITS-1).
    localparam int BIT_CNT_W  = cnt_width(FRAME_BITS);

endpackage : mash_pkg

// File: rtl/ser_edge_sync.sv
// -----------------------------------------------------------------------------
// ser_edge_sync
// Brings the asynchronous serial link into the clck domain. Bit clock and
// data each pass through a two-flop synchronizer of identical depth, so the
// relative timing between them is preserved. Every toggle of the bit clock,
// rising or falling, is reported as a single-cycle ser_edge pulse; s_data is
// the synchronized data bit valid in that same cycle.
//
// Ports
//   clck      in   system clock, rising edge
//   rst       in   asynchronous, active-high reset
//   ser_data  in   serial data pin (async)
//   ser_clk   in   serial bit clock pin (async, toggling)
//   ser_edge  out  1-cycle pulse per bit-clock toggle
//   s_data    out  synchronized data, aligned with ser_edge
// -----------------------------------------------------------------------------
module ser_edge_sync (
    input  logic clck,
    input  logic rst,
    input  logic ser_data,
    input  logic ser_clk,
    output logic ser_edge,
    output logic s_data
);

    logic [1:0] clk_sync;   // [0] first stage, [1] synchronized bit clock
    logic [1:0] data_sync;  // same depth as clk_sync
    logic       s_clk_d;    // synchronized bit clock, one cycle older

    // NOTE: sequential state uses non-blocking assignments so each flop
    // samples the value its neighbour held before this clock edge.
    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            clk_sync  <= '0;
            data_sync <= '0;
            s_clk_d   <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ser_clk};
            data_sync <= {data_sync[0], ser_data};
            s_clk_d   <= clk_sync[1];
        end
    end

    // Both polarities of the bit clock carry a bit.
    assign ser_edge = clk_sync[1] ^ s_clk_d;
    assign s_data   = data_sync[1];

endmodule : ser_edge_sync

// File: rtl/mash_serial_rx_efm1.sv
// -----------------------------------------------------------------------------
// mash_serial_rx_efm1
// Receiver for the serial residue stream of the 3-bit truncator stage.
// Rebuilds FRAME_BITS-wide words (LSB first) from the toggling bit clock,
// feeds each completed word into a first-order error-feedback accumulator
// (EFM1) whose overflow is the next MASH stage output, and drops partial
// frames when the link stalls for TIMEOUT cycles mid-frame.
//
// Ports
//   clck        in   system clock, rising edge
//   rst         in   asynchronous, active-high reset
//   ser_data    in   serial data (async to clck)
//   ser_clk     in   serial bit clock (async); every toggle is one bit
//   word_out    out  last complete frame, unsigned
//   word_valid  out  1-cycle pulse when word_out updates
//   acc_out     out  EFM1 accumulator residue
//   carry_out   out  EFM1 overflow for the most recent word
//   efm_valid   out  1-cycle pulse when acc_out/carry_out update
//   frame_err   out  1-cycle pulse when a partial frame is dropped
//
// Timing: pin toggle -> word_valid after 3 clck edges (2 sync + 1 register),
// efm_valid one edge later.
// -----------------------------------------------------------------------------
module mash_serial_rx_efm1 #(
    parameter int FRAME_BITS = mash_pkg::FRAME_BITS,
    parameter int ACC_W      = mash_pkg::ACC_W,
    parameter int TIMEOUT    = mash_pkg::TIMEOUT
) (
    input  logic                  clck,
    input  logic                  rst,
    input  logic                  ser_data,
    input  logic                  ser_clk,
    output logic [FRAME_BITS-1:0] word_out,
    output logic                  word_valid,
    output logic [ACC_W-1:0]      acc_out,
    output logic                  carry_out,
    output logic                  efm_valid,
    output logic                  frame_err
);

    localparam int BIT_CNT_W = mash_pkg::cnt_width(FRAME_BITS);
    localparam int IDLE_W    = $clog2(TIMEOUT + 1);  // must hold TIMEOUT itself
    localparam int SUM_W     = ACC_W + 1;            // accumulator plus carry

    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(FRAME_BITS - 1);
    localparam logic [IDLE_W-1:0]    IDLE_MAX  = IDLE_W'(TIMEOUT);
    localparam logic [IDLE_W-1:0]    IDLE_TRIP = IDLE_W'(TIMEOUT - 1);

    // -------------------------------------------------------------------------
    // Synchronizer and toggle detector
    // -------------------------------------------------------------------------
    logic ser_edge;
    logic s_data;

    ser_edge_sync u_sync (
        .clck     (clck),
        .rst      (rst),
        .ser_data (ser_data),
        .ser_clk  (ser_clk),
        .ser_edge (ser_edge),
        .s_data   (s_data)
    );

    // -------------------------------------------------------------------------
    // Deserializer and watchdog
    // -------------------------------------------------------------------------
    logic [FRAME_BITS-1:0] sr;
    logic [FRAME_BITS-1:0] next_sr;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [IDLE_W-1:0]     idle_cnt;
    logic                  last_bit;
    logic                  timeout_hit;

    // New bits enter at the MSB so the first bit received ends up at bit 0.
    assign next_sr  = {s_data, sr[FRAME_BITS-1:1]};
    assign last_bit = (bit_cnt == LAST_BIT);

    // Fires in the cycle where idle_cnt steps onto TIMEOUT; being a single
    // transition it yields exactly one pulse. An edge in that same cycle
    // restarts the idle count instead, so the bit is kept and no error raised.
    assign timeout_hit = !ser_edge && (idle_cnt == IDLE_TRIP) && (bit_cnt != '0);

    // NOTE: the shift register is cleared by reset along with the counters;
    // it is a few flops, and a known value simplifies debugging after reset.
    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            sr         <= '0;
            bit_cnt    <= '0;
            idle_cnt   <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (ser_edge) begin
                idle_cnt <= '0;
                sr       <= next_sr;
                if (last_bit) begin
                    word_out   <= next_sr;
                    word_valid <= 1'b1;
                    bit_cnt    <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else begin
                if (idle_cnt != IDLE_MAX) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
                if (timeout_hit) begin
                    // Stale bits left in sr are harmless: a full frame of
                    // new bits shifts them all out before the next word.
                    bit_cnt   <= '0;
                    frame_err <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // EFM1 accumulator: residue plus new word, carry is the overflow bit.
    // -------------------------------------------------------------------------
    logic [SUM_W-1:0] efm_sum;

    assign efm_sum = {1'b0, acc_out} + SUM_W'(word_out);

    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            acc_out   <= '0;
            carry_out <= 1'b0;
            efm_valid <= 1'b0;
        end else begin
            efm_valid <= word_valid;
            if (word_valid) begin
                {carry_out, acc_out} <= efm_sum;
            end
        end
    end

endmodule : mash_serial_rx_efm1

// File: tb/tb_mash_serial_rx_efm1.sv
// -----------------------------------------------------------------------------
// tb_mash_serial_rx_efm1
// Self-checking bench: a table of frames with expected accumulator results,
// hand-written sequences for latency, watchdog, reset and race corners, and
// randomized frames compared against a bit-list reference model.
// -----------------------------------------------------------------------------
module tb_mash_serial_rx_efm1;

    localparam int FB      = 3;
    localparam int AW      = 4;
    localparam int TMO     = 1024;
    localparam int ACC_MOD = 1 << AW;

    logic          clck;
    logic          rst;
    logic          ser_data;
    logic          ser_clk;
    logic [FB-1:0] word_out;
    logic          word_valid;
    logic [AW-1:0] acc_out;
    logic          carry_out;
    logic          efm_valid;
    logic          frame_err;

    mash_serial_rx_efm1 dut (
        .clck       (clck),
        .rst        (rst),
        .ser_data   (ser_data),
        .ser_clk    (ser_clk),
        .word_out   (word_out),
        .word_valid (word_valid),
        .acc_out    (acc_out),
        .carry_out  (carry_out),
        .efm_valid  (efm_valid),
        .frame_err  (frame_err)
    );

    initial clck = 1'b0;
    always #5 clck = ~clck;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- observed events (sampled on the falling edge) --------
    logic [FB-1:0] got_words[$];
    logic [AW:0]   got_efm[$];
    int            got_ferr = 0;
    int            got_both = 0;

    always @(negedge clck) begin
        if (!rst) begin
            if (word_valid) got_words.push_back(word_out);
            if (efm_valid)  got_efm.push_back({carry_out, acc_out});
            if (frame_err)  got_ferr++;
            if (word_valid && frame_err) got_both++;
        end
    end

    // ---------------- reference model: list of received bits ---------------
    bit            pend[$];
    logic [FB-1:0] exp_words[$];
    logic [AW:0]   exp_efm[$];
    int            exp_ferr = 0;
    int            model_acc = 0;
    int            since = 0;   // clck cycles since the last pin toggle

    task automatic model_reset();
        pend.delete();
        exp_words.delete();
        exp_efm.delete();
        exp_ferr  = 0;
        model_acc = 0;
        since     = 0;
    endtask

    // A toggle more than TMO cycles after the previous one means the link
    // stalled long enough to discard whatever partial frame was pending.
    task automatic model_toggle(input bit b);
        int            sum;
        logic [FB-1:0] w;
        if (since > TMO && pend.size() != 0) begin
            pend.delete();
            exp_ferr++;
        end
        since = 0;
        pend.push_back(b);
        if (pend.size() == FB) begin
            w = '0;
            for (int i = 0; i < FB; i++) w[i] = pend[i];
            pend.delete();
            exp_words.push_back(w);
            sum       = model_acc + int'(w);
            model_acc = sum % ACC_MOD;
            exp_efm.push_back({(sum >= ACC_MOD) ? 1'b1 : 1'b0, AW'(model_acc)});
        end
    endtask

    task automatic tick();
        @(negedge clck);
        since++;
    endtask

    // Data changes one cycle ahead of the toggle; toggles are 'gap' cycles apart.
    task automatic send_bit(input bit b, input int gap);
        ser_data = b;
        tick();
        ser_clk = ~ser_clk;
        model_toggle(b);
        repeat (gap - 1) tick();
    endtask

    task automatic send_frame(input logic [FB-1:0] w, input int gap);
        logic [FB-1:0] v;
        v = w;
        for (int i = 0; i < FB; i++) send_bit(v[i], gap);
    endtask

    task automatic drain();
        repeat (8) tick();
    endtask

    task automatic clear_obs();
        got_words.delete();
        got_efm.delete();
        got_ferr = 0;
        got_both = 0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ser_clk  = 1'b0;
        ser_data = 1'b0;
        repeat (3) @(negedge clck);
        clear_obs();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_queues(input string tag);
        int n;
        check({tag, "_nwords"}, got_words.size(), exp_words.size());
        n = (got_words.size() < exp_words.size()) ? got_words.size() : exp_words.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_word%0d", tag, i), got_words[i], exp_words[i]);
        check({tag, "_nefm"}, got_efm.size(), exp_efm.size());
        n = (got_efm.size() < exp_efm.size()) ? got_efm.size() : exp_efm.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_efm%0d", tag, i), got_efm[i], exp_efm[i]);
        check({tag, "_ferr"}, got_ferr, exp_ferr);
        check({tag, "_wv_and_fe"}, got_both, 0);
        clear_obs();
        exp_words.delete();
        exp_efm.delete();
        exp_ferr = 0;
    endtask

    // ---------------- table of frames with expected EFM1 results -----------
    typedef struct {
        logic [FB-1:0] word;
        logic [AW-1:0] acc;
        logic          carry;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int first_wv, first_ev, n_wv, first_fe;

        tbl[0] = '{word: 3'd7, acc: 4'd7,  carry: 1'b0};
        tbl[1] = '{word: 3'd7, acc: 4'd14, carry: 1'b0};
        tbl[2] = '{word: 3'd7, acc: 4'd5,  carry: 1'b1};
        tbl[3] = '{word: 3'd2, acc: 4'd7,  carry: 1'b0};
        tbl[4] = '{word: 3'd0, acc: 4'd7,  carry: 1'b0};
        tbl[5] = '{word: 3'd7, acc: 4'd14, carry: 1'b0};
        tbl[6] = '{word: 3'd3, acc: 4'd1,  carry: 1'b1};

        rst = 1'b1; ser_clk = 1'b0; ser_data = 1'b0;
        do_reset();

        // Reset state
        check("rst_word_out",   word_out,   0);
        check("rst_word_valid", word_valid, 0);
        check("rst_acc_out",    acc_out,    0);
        check("rst_carry_out",  carry_out,  0);
        check("rst_efm_valid",  efm_valid,  0);
        check("rst_frame_err",  frame_err,  0);

        // 1. Bits 1,0,1 every 256 cycles; measure latency of the last toggle.
        send_bit(1'b1, 256);
        send_bit(1'b0, 256);
        ser_data = 1'b1;
        tick();
        ser_clk = ~ser_clk;
        model_toggle(1'b1);
        first_wv = 0; first_ev = 0; n_wv = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (word_valid) begin
                n_wv++;
                if (first_wv == 0) first_wv = k;
            end
            if (efm_valid && first_ev == 0) first_ev = k;
        end
        check("t1_word_out",   word_out, 3'b101);
        check("t1_wv_latency", first_wv, 3);
        check("t1_wv_pulses",  n_wv,     1);
        check("t1_ev_latency", first_ev, 4);
        check_queues("t1");

        // 2. Table-driven frames; accumulator starts from zero.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i].word, 4);
            drain();
            check($sformatf("t2_word%0d", i),  word_out,  tbl[i].word);
            check($sformatf("t2_acc%0d", i),   acc_out,   tbl[i].acc);
            check($sformatf("t2_carry%0d", i), carry_out, tbl[i].carry);
        end
        check_queues("t2");

        // 3. Two bits then a long stall: one frame_err, then a clean frame.
        do_reset();
        send_bit(1'b1, 2);
        ser_data = 1'b0;
        tick();
        ser_clk = ~ser_clk;
        model_toggle(1'b0);
        first_fe = 0;
        for (int k = 1; k <= 1100; k++) begin
            tick();
            if (frame_err && first_fe == 0) first_fe = k;
        end
        check("t3_fe_latency", first_fe, TMO + 3);
        send_frame(3'b110, 2);
        drain();
        check("t3_word_out", word_out, 3'b110);
        check_queues("t3");

        // 4. Asynchronous reset mid-frame clears outputs immediately.
        do_reset();
        send_frame(3'd7, 3);
        drain();
        check("t4_pre_word", word_out, 7);
        send_bit(1'b1, 3);
        send_bit(1'b1, 3);
        #2 rst = 1'b1;
        #1;
        check("t4_async_word", word_out,   0);
        check("t4_async_acc",  acc_out,    0);
        check("t4_async_cry",  carry_out,  0);
        check("t4_async_wv",   word_valid, 0);
        check("t4_async_ev",   efm_valid,  0);
        check("t4_async_fe",   frame_err,  0);
        do_reset();
        send_frame(3'd1, 3);
        drain();
        check("t4_word_out", word_out, 1);
        check_queues("t4");

        // 5. Toggles exactly TMO cycles apart race the watchdog; edge wins.
        do_reset();
        send_bit(1'b1, TMO);
        send_bit(1'b1, TMO);
        send_bit(1'b0, 2);
        drain();
        check("t5_word_out", word_out, 3'b011);
        check_queues("t5");

        // 6. Random frames at the fastest legal rate, then with random gaps.
        do_reset();
        for (int i = 0; i < 10; i++) send_frame(FB'($urandom_range(0, 7)), 2);
        drain();
        check_queues("t6_fast");
        for (int i = 0; i < 20 * FB; i++)
            send_bit(1'($urandom_range(0, 1)), int'($urandom_range(2, 6)));
        drain();
        check_queues("t6_rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mash_serial_rx_efm1
